// File: rtl/aes_key_pkg.sv
// Shared AES-192 key-schedule types, constants, Rcon table, FSM states and S-box.
package aes_key_pkg;

  typedef logic [31:0] aes_word_t;

  localparam int AES192_NK        = 6;
  localparam int AES192_NSUBKEYS  = 13;
  localparam int AES192_FWD_STEPS = 23;

  // Index 0 is a null Rcon so that an index of zero can mean "no transform".
  localparam logic [8:0][7:0] AES_RCON = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                                          8'h04, 8'h02, 8'h01, 8'h00};

`ifdef AES192_INV_KEY_LOAD_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FWD = 2'd1, ST_EMIT = 2'd2} ks_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EMIT = 2'd2} ks_state_t;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: field inverse as a^254 in GF(2^8), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Reverse step: word n_m is w[j], j = 4r - 3 - m; returns Rcon index or 0.
  function automatic logic [3:0] rev_rcon_idx(input logic [3:0] r, input int m);
    int j;
    j = 4 * int'(r) - 3 - m;
    if (j >= 0 && (j % 6) == 0) return 4'(j / 6 + 1);
    return 4'd0;
  endfunction

  function automatic logic rev_word_valid(input logic [3:0] r, input int m);
    return (4 * int'(r) - 3 - m) >= 0;
  endfunction

  // Forward step s produces w[i], i = 6 + 2s + off.
  function automatic logic [3:0] fwd_rcon_idx(input logic [4:0] s, input int off);
    int i;
    i = 6 + 2 * int'(s) + off;
    if ((i % 6) == 0) return 4'(i / 6);
    return 4'd0;
  endfunction

endpackage

// File: rtl/aes_word_xform.sv
// Combinational SubWord(RotWord(word)) ^ {Rcon[rcon_idx], 24'h0}.
module aes_word_xform
  import aes_key_pkg::*;
(
  input  aes_word_t  word,
  input  logic [3:0] rcon_idx,
  output aes_word_t  xform
);

  aes_word_t  rot;
  logic [7:0] rc;

  assign rot   = {word[23:0], word[31:24]};
  assign rc    = (rcon_idx <= 4'd8) ? AES_RCON[rcon_idx] : 8'h00;
  assign xform = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

endmodule

// File: rtl/aes192_inv_key_schedule.sv
// AES-192 reverse round-key generator emitting subkeys 12..0 over valid/ready.
// Optional AES192_INV_KEY_LOAD_EN: load the cipher key and run the forward schedule first.
module aes192_inv_key_schedule
  import aes_key_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [191:0] long_key,
  output logic [127:0] subkey,
  output logic         valid_skey,
  input  logic         skey_ready,
  output logic         last_skey,
  output logic         busy
);

  ks_state_t    state;
  logic [191:0] win;
  logic [3:0]   r;
  aes_word_t    rev_word [4];
  logic [191:0] win_rev;

  assign subkey = win[127:0];

  // All four older words derive from the current window only, so no chaining.
  for (genvar m = 0; m < 4; m++) begin : g_rev
    aes_word_t  src6;
    aes_word_t  src5;
    aes_word_t  t_out;
    logic [3:0] idx;
    assign src6 = win[191-32*(5-m) -: 32];
    assign src5 = win[191-32*(4-m) -: 32];
    assign idx  = rev_rcon_idx(r, m);
    aes_word_xform u_xform (.word(src5), .rcon_idx(idx), .xform(t_out));
    assign rev_word[m] = rev_word_valid(r, m) ?
                         (src6 ^ ((idx != 4'd0) ? t_out : src5)) : '0;
  end

  assign win_rev = {rev_word[3], rev_word[2], rev_word[1], rev_word[0], win[191:128]};

`ifdef AES192_INV_KEY_LOAD_EN
  logic [4:0] step;
  logic [3:0] idx_a;
  logic [3:0] idx_b;
  aes_word_t  xf_a;
  aes_word_t  xf_b;
  aes_word_t  fwd_a;
  aes_word_t  fwd_b;

  // Second forward word chains off the first, unlike the reverse step.
  assign idx_a = fwd_rcon_idx(step, 0);
  assign idx_b = fwd_rcon_idx(step, 1);
  aes_word_xform u_fwd_a (.word(win[31:0]), .rcon_idx(idx_a), .xform(xf_a));
  assign fwd_a = win[191:160] ^ ((idx_a != 4'd0) ? xf_a : win[31:0]);
  aes_word_xform u_fwd_b (.word(fwd_a), .rcon_idx(idx_b), .xform(xf_b));
  assign fwd_b = win[159:128] ^ ((idx_b != 4'd0) ? xf_b : fwd_a);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      win        <= '0;
      r          <= '0;
      valid_skey <= 1'b0;
      last_skey  <= 1'b0;
      busy       <= 1'b0;
`ifdef AES192_INV_KEY_LOAD_EN
      step       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            win  <= long_key;
            r    <= 4'(AES192_NSUBKEYS - 1);
            busy <= 1'b1;
`ifdef AES192_INV_KEY_LOAD_EN
            state <= ST_FWD;
            step  <= '0;
`else
            state      <= ST_EMIT;
            valid_skey <= 1'b1;
`endif
          end
        end
`ifdef AES192_INV_KEY_LOAD_EN
        ST_FWD: begin
          win  <= {win[127:0], fwd_a, fwd_b};
          step <= step + 5'd1;
          if (step == 5'(AES192_FWD_STEPS - 1)) begin
            state      <= ST_EMIT;
            valid_skey <= 1'b1;
          end
        end
`endif
        ST_EMIT: begin
          if (skey_ready) begin
            if (r == 4'd0) begin
              state      <= ST_IDLE;
              win        <= '0;
              valid_skey <= 1'b0;
              last_skey  <= 1'b0;
              busy       <= 1'b0;
            end else begin
              r         <= r - 4'd1;
              win       <= win_rev;
              last_skey <= (r == 4'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes192_inv_key_schedule.sv
// Directed self-checking bench for aes192_inv_key_schedule (honours AES192_INV_KEY_LOAD_EN).
`timescale 1ns/1ps
module tb_aes192_inv_key_schedule;

  logic         clk;
  logic         reset;
  logic         start;
  logic [191:0] long_key;
  logic [127:0] subkey;
  logic         valid_skey;
  logic         skey_ready;
  logic         last_skey;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [191:0] CIPHER_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] OTHER_KEY  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] SK12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] SK1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] SK0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
`ifdef AES192_INV_KEY_LOAD_EN
  localparam int LOAD_LAT = 24;
`else
  localparam int LOAD_LAT = 1;
`endif

  logic [0:255][7:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [31:0]  w      [0:51];
  logic [127:0] exp_sk [0:12];
  logic [191:0] load_key;

  aes192_inv_key_schedule dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .long_key   (long_key),
    .subkey     (subkey),
    .valid_skey (valid_skey),
    .skey_ready (skey_ready),
    .last_skey  (last_skey),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sub_rot(input logic [31:0] x);
    return {sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]], sbox_tab[x[31:24]]};
  endfunction

  // Reference forward expansion; Rcon is generated by doubling rather than a table.
  task automatic build_model(input logic [191:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
    rc = 8'h01;
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t  = sub_rot(t) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0};
      end
      w[i] = w[i-6] ^ t;
    end
    for (int k = 0; k < 13; k++) exp_sk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
`ifdef AES192_INV_KEY_LOAD_EN
    load_key = key;
`else
    load_key = {w[46], w[47], w[48], w[49], w[50], w[51]};
`endif
  endtask

  // Pulses start from a negedge and counts negedges until valid_skey (bounded).
  task automatic launch(input logic [191:0] key, output int lat);
    start    = 1'b1;
    long_key = key;
    lat      = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!valid_skey && lat < 100);
  endtask

  task automatic test_reset;
    start = 1'b0; skey_ready = 1'b0; long_key = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({subkey, valid_skey, last_skey, busy} !== 131'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got sk=%h v=%b l=%b b=%b, expected all 0",
               subkey, valid_skey, last_skey, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({subkey, valid_skey, busy} !== 130'h0) begin
      errors++;
      $display("[TB] FAIL idle_after_release: got sk=%h v=%b b=%b, expected 0", subkey, valid_skey, busy);
    end
  endtask

  task automatic test_nominal;
    int lat, beats, cyc;
    build_model(CIPHER_KEY);
    skey_ready = 1'b1;
    launch(load_key, lat);
    checks++;
    if (lat !== LOAD_LAT) begin
      errors++; $display("[TB] FAIL load_latency: got %0d expected %0d", lat, LOAD_LAT);
    end
    checks++;
    if (subkey !== SK12) begin
      errors++; $display("[TB] FAIL subkey12_fips: got %h expected %h", subkey, SK12);
    end
    beats = 0; cyc = 0;
    while (valid_skey && cyc < 40) begin
      if (beats < 13) begin
        checks++;
        if (subkey !== exp_sk[12-beats] || last_skey !== (beats == 12)) begin
          errors++;
          $display("[TB] FAIL nominal_seq beat %0d: got %h last=%b expected %h last=%b",
                   beats, subkey, last_skey, exp_sk[12-beats], (beats == 12));
        end
      end
      if (beats == 11) begin
        checks++;
        if (subkey !== SK1) begin
          errors++; $display("[TB] FAIL subkey1_fips: got %h expected %h", subkey, SK1);
        end
      end
      if (beats == 12) begin
        checks++;
        if (subkey !== SK0 || last_skey !== 1'b1) begin
          errors++; $display("[TB] FAIL subkey0_fips: got %h last=%b expected %h last=1", subkey, last_skey, SK0);
        end
      end
      beats++; cyc++;
      @(negedge clk);
    end
    checks++;
    if (beats !== 13) begin
      errors++; $display("[TB] FAIL beat_count: got %0d expected 13", beats);
    end
    checks++;
    if ({subkey, valid_skey, last_skey, busy} !== 131'h0) begin
      errors++;
      $display("[TB] FAIL idle_after_last: got sk=%h v=%b l=%b b=%b expected 0", subkey, valid_skey, last_skey, busy);
    end
  endtask

  task automatic test_stall;
    int lat, beats, cyc;
    logic         held;
    logic [127:0] prev_sk;
    build_model(CIPHER_KEY);
    skey_ready = 1'b0;
    launch(load_key, lat);
    checks++;
    if (lat !== LOAD_LAT) begin
      errors++; $display("[TB] FAIL stall_latency: got %0d expected %0d", lat, LOAD_LAT);
    end
    beats = 0; cyc = 0; held = 1'b0; prev_sk = '0;
    while (beats < 13 && cyc < 400) begin
      checks++;
      if (valid_skey !== 1'b1 || subkey !== exp_sk[12-beats]) begin
        errors++;
        $display("[TB] FAIL stall_seq beat %0d: got v=%b %h expected v=1 %h", beats, valid_skey, subkey, exp_sk[12-beats]);
      end
      if (held) begin
        checks++;
        if (subkey !== prev_sk) begin
          errors++; $display("[TB] FAIL stall_hold: got %h expected %h", subkey, prev_sk);
        end
      end
      skey_ready = ($urandom_range(0, 99) >= 40);
      held       = !skey_ready;
      prev_sk    = subkey;
      if (skey_ready) beats++;
      cyc++;
      @(negedge clk);
    end
    skey_ready = 1'b0;
    checks++;
    if (beats !== 13 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_complete: got beats=%0d busy=%b expected 13 busy=0", beats, busy);
    end
  endtask

  task automatic test_start_ignored;
    int lat, beats, cyc;
    build_model(CIPHER_KEY);
    skey_ready = 1'b1;
    launch(load_key, lat);
    checks++;
    if (lat !== LOAD_LAT) begin
      errors++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, LOAD_LAT);
    end
    beats = 0; cyc = 0;
    while (valid_skey && cyc < 40) begin
      start    = (beats >= 3 && beats <= 5);
      long_key = start ? OTHER_KEY : load_key;
      if (beats < 13) begin
        checks++;
        if (subkey !== exp_sk[12-beats]) begin
          errors++; $display("[TB] FAIL ignore_seq beat %0d: got %h expected %h", beats, subkey, exp_sk[12-beats]);
        end
      end
      beats++; cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (beats !== 13 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL ignore_count: got beats=%0d busy=%b expected 13 busy=0", beats, busy);
    end
  endtask

  task automatic test_reset_mid;
    int lat, beats, cyc;
    build_model(CIPHER_KEY);
    skey_ready = 1'b1;
    launch(load_key, lat);
    beats = 0; cyc = 0;
    while (valid_skey && beats < 5 && cyc < 40) begin
      beats++; cyc++;
      @(negedge clk);
    end
    checks++;
    if (subkey !== exp_sk[7]) begin
      errors++; $display("[TB] FAIL sixth_subkey: got %h expected %h", subkey, exp_sk[7]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({subkey, valid_skey, last_skey, busy} !== 131'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got sk=%h v=%b l=%b b=%b expected all 0", subkey, valid_skey, last_skey, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    launch(load_key, lat);
    checks++;
    if (lat !== LOAD_LAT || subkey !== exp_sk[12]) begin
      errors++;
      $display("[TB] FAIL restart_after_reset: got lat=%0d %h expected lat=%0d %h", lat, subkey, LOAD_LAT, exp_sk[12]);
    end
    cyc = 0;
    while (valid_skey && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int lat, beats, cyc;
    build_model(CIPHER_KEY);
    skey_ready = 1'b1;
    launch(load_key, lat);
    cyc = 0;
    while (valid_skey && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || valid_skey !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_idle_gap: got busy=%b v=%b expected 0 0", busy, valid_skey);
    end
    launch(load_key, lat);
    checks++;
    if (lat !== LOAD_LAT) begin
      errors++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, LOAD_LAT);
    end
    beats = 0; cyc = 0;
    while (valid_skey && cyc < 40) begin
      if (beats < 13) begin
        checks++;
        if (subkey !== exp_sk[12-beats]) begin
          errors++; $display("[TB] FAIL b2b_seq beat %0d: got %h expected %h", beats, subkey, exp_sk[12-beats]);
        end
      end
      beats++; cyc++;
      @(negedge clk);
    end
    checks++;
    if (beats !== 13) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d expected 13", beats);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_stall;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
